// File: rtl/next_pc_predictor_pkg.sv
// Shared constants and types for the next-PC predictor slice.
// Holds the RV32 opcode values the predictor recognises, the instruction
// width, the default table geometry and a small opcode classifier used by
// the top level.
package next_pc_predictor_pkg;

  localparam int DATA_WIDTH = 32;
  // Width of the opcode field, which occupies inst[OP_RANGE-1:0]
  localparam int OP_RANGE = 7;

  localparam logic [OP_RANGE-1:0] BRANCH_OP = 7'b1100011;
  localparam logic [OP_RANGE-1:0] JAL_OP    = 7'b1101111;

  localparam int PREDICTION_INDEX_BITS = 6;
  localparam int PREDICTION_CNT_BITS   = 2;

  typedef enum logic [1:0] {
    OP_OTHER,
    OP_BRANCH,
    OP_JAL
  } opClass_e;

  // JALR and every other opcode fall into OP_OTHER and are fetched sequentially
  function automatic opClass_e decodeOp(input logic [OP_RANGE-1:0] opcode);
    opClass_e cls;
    cls = OP_OTHER;
    if (opcode == BRANCH_OP) cls = OP_BRANCH;
    else if (opcode == JAL_OP) cls = OP_JAL;
    return cls;
  endfunction

endpackage

// File: rtl/next_pc_predictor_if.sv
// Bus between the fetcher / branch-resolve logic and the next-PC predictor.
// Ports carried:
//   fetch side   : ena, in_fetcher_ena, in_last_pc, in_last_inst
//                  -> out_next_pc, out_next_taken, out_pred_index
//   resolve side : in_misbranch, in_forwarding_correct_address,
//                  in_update_valid, in_update_index,
//                  in_forwarding_branch_taken -> out_rollback
// Modports: master (the environment driving the predictor), slave (predictor).
interface next_pc_predictor_if
  import next_pc_predictor_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = PREDICTION_INDEX_BITS
);

  logic                  ena;
  logic                  in_fetcher_ena;
  logic [ADDR_WIDTH-1:0] in_last_pc;
  logic [DATA_WIDTH-1:0] in_last_inst;
  logic [ADDR_WIDTH-1:0] out_next_pc;
  logic                  out_next_taken;
  logic [INDEX_BITS-1:0] out_pred_index;
  logic                  in_misbranch;
  logic [ADDR_WIDTH-1:0] in_forwarding_correct_address;
  logic                  in_update_valid;
  logic [INDEX_BITS-1:0] in_update_index;
  logic                  in_forwarding_branch_taken;
  logic                  out_rollback;

  modport master (
    output ena, in_fetcher_ena, in_last_pc, in_last_inst,
    output in_misbranch, in_forwarding_correct_address,
    output in_update_valid, in_update_index, in_forwarding_branch_taken,
    input  out_next_pc, out_next_taken, out_pred_index, out_rollback
  );

  modport slave (
    input  ena, in_fetcher_ena, in_last_pc, in_last_inst,
    input  in_misbranch, in_forwarding_correct_address,
    input  in_update_valid, in_update_index, in_forwarding_branch_taken,
    output out_next_pc, out_next_taken, out_pred_index, out_rollback
  );

endinterface

// File: rtl/next_pc_predictor_bht_table.sv
// Branch history table: 2**INDEX_BITS saturating counters of CNT_BITS each.
// Ports:
//   clk, rst           clock and asynchronous active-low reset
//   rdIndex_i          combinational lookup index
//   rdCount_o          counter value at rdIndex_i (pre-update on a same-cycle write)
//   updValid_i         apply an update this cycle
//   updIndex_i         counter to update
//   updTaken_i         1 = count up, 0 = count down (saturating both ways)
// Every counter resets to weakly not-taken, 2**(CNT_BITS-1)-1.
module next_pc_predictor_bht_table #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rdIndex_i,
  output logic [CNT_BITS-1:0]   rdCount_o,
  input  logic                  updValid_i,
  input  logic [INDEX_BITS-1:0] updIndex_i,
  input  logic                  updTaken_i
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic [CNT_BITS-1:0] cnt_q [DEPTH];
  logic [CNT_BITS-1:0] updCurrent;
  logic [CNT_BITS-1:0] cntNext_d;

  // Read port sees the registered array, so a same-cycle update is invisible
  assign rdCount_o  = cnt_q[rdIndex_i];
  assign updCurrent = cnt_q[updIndex_i];

  // Saturating step: hold at all-ones when taken, hold at zero when not taken
  always_comb begin
    cntNext_d = updCurrent;
    if (updTaken_i) begin
      if (updCurrent != CNT_MAX) cntNext_d = updCurrent + CNT_BITS'(1);
    end else begin
      if (updCurrent != '0) cntNext_d = updCurrent - CNT_BITS'(1);
    end
  end

  // Counter storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else if (updValid_i) begin
      cnt_q[updIndex_i] <= cntNext_d;
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Next-PC generator for the fetch stage.
// Predicts conditional branches from a table of saturating counters, JAL by
// its immediate, and everything else (including JALR) as pc+4. A resolved
// misprediction redirects fetch and raises a one-cycle rollback pulse.
// Ports:
//   clk, rst  clock and asynchronous active-low reset
//   bus       next_pc_predictor_if.slave (fetch inputs, resolve inputs,
//             registered next pc / taken / index / rollback outputs)
// Optional feature: define GSHARE_EN to XOR a non-speculative global history
// register into the table index; without it the index is pc[INDEX_BITS+1:2].
module next_pc_predictor
  import next_pc_predictor_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = PREDICTION_INDEX_BITS,
  parameter int CNT_BITS   = PREDICTION_CNT_BITS,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  next_pc_predictor_if.slave bus
);

  opClass_e              opClass;
  logic signed [31:0]    branchImm;
  logic signed [31:0]    jalImm;
  logic [ADDR_WIDTH-1:0] pcPlus4;
  logic [ADDR_WIDTH-1:0] branchTarget;
  logic [ADDR_WIDTH-1:0] jalTarget;
  logic [INDEX_BITS-1:0] pcIndex;
  logic [INDEX_BITS-1:0] lookupIndex;
  logic [CNT_BITS-1:0]   lookupCount;
  logic                  lookupTaken;
  logic                  fetchFire;

  logic [ADDR_WIDTH-1:0] nextPc_q, nextPc_d;
  logic                  nextTaken_q, nextTaken_d;
  logic [INDEX_BITS-1:0] predIndex_q, predIndex_d;
  logic                  rollback_q, rollback_d;

  assign opClass = decodeOp(bus.in_last_inst[OP_RANGE-1:0]);

  // RV32 B-type and J-type immediates, sign-extended to 32 bits
  assign branchImm = {{19{bus.in_last_inst[31]}}, bus.in_last_inst[31], bus.in_last_inst[7],
                      bus.in_last_inst[30:25], bus.in_last_inst[11:8], 1'b0};
  assign jalImm    = {{11{bus.in_last_inst[31]}}, bus.in_last_inst[31], bus.in_last_inst[19:12],
                      bus.in_last_inst[20], bus.in_last_inst[30:21], 1'b0};

  assign pcPlus4      = bus.in_last_pc + ADDR_WIDTH'(4);
  assign branchTarget = bus.in_last_pc + ADDR_WIDTH'(branchImm);
  assign jalTarget    = bus.in_last_pc + ADDR_WIDTH'(jalImm);

  assign pcIndex = bus.in_last_pc[INDEX_BITS+1:2];

`ifdef GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;

  // History follows resolved outcomes only, so a misbranch never needs repair
  always_comb begin
    ghr_d = ghr_q;
    if (bus.in_update_valid) ghr_d = {ghr_q[INDEX_BITS-2:0], bus.in_forwarding_branch_taken};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  assign lookupIndex = pcIndex ^ ghr_q;
`else
  assign lookupIndex = pcIndex;
`endif

  next_pc_predictor_bht_table #(
    .INDEX_BITS(INDEX_BITS),
    .CNT_BITS  (CNT_BITS)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rdIndex_i (lookupIndex),
    .rdCount_o (lookupCount),
    .updValid_i(bus.in_update_valid),
    .updIndex_i(bus.in_update_index),
    .updTaken_i(bus.in_forwarding_branch_taken)
  );

  assign lookupTaken = lookupCount[CNT_BITS-1];
  assign fetchFire   = bus.ena & bus.in_fetcher_ena;

  // Redirect beats fetch; the stall only gates the fetch path. The predicted
  // index is only refreshed for branches, since only they carry it to resolve.
  always_comb begin
    nextPc_d    = nextPc_q;
    nextTaken_d = nextTaken_q;
    predIndex_d = predIndex_q;
    rollback_d  = 1'b0;
    if (bus.in_misbranch) begin
      nextPc_d    = bus.in_forwarding_correct_address;
      nextTaken_d = 1'b0;
      rollback_d  = 1'b1;
    end else if (fetchFire) begin
      case (opClass)
        OP_BRANCH: begin
          nextPc_d    = lookupTaken ? branchTarget : pcPlus4;
          nextTaken_d = lookupTaken;
          predIndex_d = lookupIndex;
        end
        OP_JAL: begin
          nextPc_d    = jalTarget;
          nextTaken_d = 1'b0;
        end
        default: begin
          nextPc_d    = pcPlus4;
          nextTaken_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nextPc_q    <= RESET_PC;
      nextTaken_q <= 1'b0;
      predIndex_q <= '0;
      rollback_q  <= 1'b0;
    end else begin
      nextPc_q    <= nextPc_d;
      nextTaken_q <= nextTaken_d;
      predIndex_q <= predIndex_d;
      rollback_q  <= rollback_d;
    end
  end

  assign bus.out_next_pc    = nextPc_q;
  assign bus.out_next_taken = nextTaken_q;
  assign bus.out_pred_index = predIndex_q;
  assign bus.out_rollback   = rollback_q;

endmodule
